// File: rtl/crtc_mode_loader.sv
// crtc_mode_loader: walks a mode ROM and programs a 6845-style CRTC
// over its index/data port, with optional masked readback checking.
module crtc_mode_loader #(
    parameter int MODE_W     = 2,
    parameter int GAP_CYCLES = 1,
    parameter bit VERIFY     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              lock,
    output logic [MODE_W+3:0] tbl_addr,
    input  logic [7:0]        tbl_data,
    output logic              crtc_cs,
    output logic              crtc_a0,
    output logic              crtc_write,
    output logic              crtc_read,
    output logic [7:0]        crtc_bus,
    input  logic [7:0]        crtc_bus_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        err_reg,
    output logic              lock_skip
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_IDX,
        S_DAT,
        S_RD,
        S_GAP,
        S_NEXT,
        S_FIN
    } state_t;

    // Reload value for the idle-gap counter; unused when there is no gap.
    localparam logic [3:0] GAP_M1 =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [3:0]          idx_q, idx_d;
    logic [7:0]          data_q, data_d;
    logic                fcnt_q, fcnt_d;
    logic [3:0]          gap_q, gap_d;
    logic                err_q, err_d;
    logic [4:0]          err_reg_q, err_reg_d;
    logic                lock_skip_q, lock_skip_d;

    logic                strobe_end;
    state_t              strobe_tgt;
    logic [7:0]          cur_mask;
    logic                mismatch;

    // Writable-bit mask of each CRTC register; bits outside it read back
    // as whatever the CRTC chooses and must not be compared.
    function automatic logic [7:0] reg_mask(input logic [3:0] i);
        logic [7:0] m;
        case (i)
            4'd3:                      m = 8'h0F;
            4'd4, 4'd6, 4'd7, 4'd10:   m = 8'h7F;
            4'd5, 4'd9, 4'd11:         m = 8'h1F;
            4'd12, 4'd14:              m = 8'h3F;
            default:                   m = 8'hFF;
        endcase
        return m;
    endfunction

    // Masked readback comparison for the register currently addressed.
    always_comb begin
        cur_mask = reg_mask(idx_q);
        mismatch = ((crtc_bus_in & cur_mask) != (data_q & cur_mask));
    end

    // Next-state logic and bus strobes decoded from the current state.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        data_d      = data_q;
        fcnt_d      = fcnt_q;
        gap_d       = gap_q;
        err_d       = err_q;
        err_reg_d   = err_reg_q;
        lock_skip_d = lock_skip_q;
        strobe_end  = 1'b0;
        strobe_tgt  = S_NEXT;
        crtc_cs     = 1'b0;
        crtc_a0     = 1'b0;
        crtc_write  = 1'b0;
        crtc_read   = 1'b0;
        crtc_bus    = 8'h00;
        done        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    idx_d       = 4'd0;
                    fcnt_d      = 1'b0;
                    err_d       = 1'b0;
                    err_reg_d   = 5'd0;
                    lock_skip_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!fcnt_q) begin
                    fcnt_d = 1'b1;
                end else begin
                    fcnt_d = 1'b0;
                    data_d = tbl_data;
                    if (lock && (idx_q <= 4'd9)) begin
                        lock_skip_d = 1'b1;
                        state_d     = S_NEXT;
                    end else begin
                        state_d = S_IDX;
                    end
                end
            end
            S_IDX: begin
                crtc_cs    = 1'b1;
                crtc_write = 1'b1;
                crtc_bus   = {4'd0, idx_q};
                strobe_end = 1'b1;
                strobe_tgt = S_DAT;
            end
            S_DAT: begin
                crtc_cs    = 1'b1;
                crtc_a0    = 1'b1;
                crtc_write = 1'b1;
                crtc_bus   = data_q;
                strobe_end = 1'b1;
                strobe_tgt = VERIFY ? S_RD : S_NEXT;
            end
            S_RD: begin
                crtc_cs    = 1'b1;
                crtc_a0    = 1'b1;
                crtc_read  = 1'b1;
                strobe_end = 1'b1;
                strobe_tgt = S_NEXT;
                if (mismatch && !err_q) begin
                    err_d     = 1'b1;
                    err_reg_d = {1'b0, idx_q};
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ret_q;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_NEXT: begin
                if (idx_q == 4'd15) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = (idx_q == 4'd7) ? 4'd9 : idx_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (strobe_end) begin
            if (GAP_CYCLES == 0) begin
                state_d = strobe_tgt;
            end else begin
                state_d = S_GAP;
                ret_d   = strobe_tgt;
                gap_d   = GAP_M1;
            end
        end
    end

    // Sequencer state and sticky status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            mode_q      <= '0;
            idx_q       <= 4'd0;
            data_q      <= 8'h00;
            fcnt_q      <= 1'b0;
            gap_q       <= 4'd0;
            err_q       <= 1'b0;
            err_reg_q   <= 5'd0;
            lock_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            fcnt_q      <= fcnt_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            err_reg_q   <= err_reg_d;
            lock_skip_q <= lock_skip_d;
        end
    end

    // Status outputs; busy covers every working state except the done cycle.
    always_comb begin
        tbl_addr  = {mode_q, idx_q};
        busy      = (state_q != S_IDLE) && (state_q != S_FIN);
        err       = err_q;
        err_reg   = err_reg_q;
        lock_skip = lock_skip_q;
    end

endmodule

// File: tb/tb_crtc_mode_loader.sv
// tb_crtc_mode_loader: random ROM contents and CRTC behaviour checked
// against a register-list model of the programming sequence.
module tb_crtc_mode_loader;

    localparam int GAP = 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       lock;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_data;
    logic       crtc_cs, crtc_a0, crtc_write, crtc_read;
    logic [7:0] crtc_bus, crtc_bus_in;
    logic       busy, done, err, lock_skip;
    logic [4:0] err_reg;

    logic       start2;
    logic [5:0] tbl_addr2;
    logic [7:0] tbl_data2;
    logic       cs2, a02, wr2, rd2;
    logic [7:0] bus2;
    logic       busy2, done2, err2, lock_skip2;
    logic [4:0] err_reg2;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rom [0:63];
    logic [7:0] smask [0:15];
    logic [4:0] c_idx;
    logic [7:0] c_reg [0:31];
    logic       force_en;
    logic [4:0] force_idx;
    logic [7:0] force_val;
    logic [8:0] wlog [$];
    int         rd_cnt = 0;
    int         viol = 0;
    int         w2_cnt = 0;
    int         r2_cnt = 0;

    logic [8:0] exp_q [$];
    int         exp_busy;
    int         exp_rd;
    logic       exp_err;
    logic [4:0] exp_ereg;
    logic       exp_skip;

    crtc_mode_loader #(.MODE_W(2), .GAP_CYCLES(GAP), .VERIFY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lock(lock),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .crtc_cs(crtc_cs), .crtc_a0(crtc_a0), .crtc_write(crtc_write),
        .crtc_read(crtc_read), .crtc_bus(crtc_bus), .crtc_bus_in(crtc_bus_in),
        .busy(busy), .done(done), .err(err), .err_reg(err_reg),
        .lock_skip(lock_skip)
    );

    crtc_mode_loader #(.MODE_W(2), .GAP_CYCLES(0), .VERIFY(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(2'd0), .lock(1'b0),
        .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
        .crtc_cs(cs2), .crtc_a0(a02), .crtc_write(wr2),
        .crtc_read(rd2), .crtc_bus(bus2), .crtc_bus_in(8'h00),
        .busy(busy2), .done(done2), .err(err2), .err_reg(err_reg2),
        .lock_skip(lock_skip2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous mode ROM shared by both loaders.
    always @(posedge clk) begin
        tbl_data  <= rom[tbl_addr];
        tbl_data2 <= rom[tbl_addr2];
    end

    // CRTC model: index latch, storage limited by smask, write log.
    always @(posedge clk) begin
        if (crtc_cs && crtc_write) begin
            wlog.push_back({crtc_a0, crtc_bus});
            if (!crtc_a0) c_idx <= crtc_bus[4:0];
            else c_reg[c_idx] <= crtc_bus & smask[c_idx[3:0]];
        end
        if (crtc_read) rd_cnt++;
        if (wr2) w2_cnt++;
        if (rd2) r2_cnt++;
    end

    assign crtc_bus_in = (force_en && c_idx == force_idx) ? force_val
                                                          : c_reg[c_idx];

    // Bus protocol watch: exclusive strobes, cs tracks strobes, quiet idle.
    always @(negedge clk) begin
        if ((crtc_write && crtc_read) ||
            (crtc_cs != (crtc_write | crtc_read)) ||
            (!busy && (crtc_cs || crtc_bus != 8'h00)))
            viol++;
    end

    function automatic logic [7:0] mask_of(input int r);
        case (r)
            3:              return 8'h0F;
            4, 6, 7, 10:    return 8'h7F;
            5, 9, 11:       return 8'h1F;
            12, 14:         return 8'h3F;
            default:        return 8'hFF;
        endcase
    endfunction

    // Expected register list, timing and status for one run.
    function automatic void build(input int m, input bit lk);
        logic [7:0] d, rb;
        exp_q.delete();
        exp_busy = 0;
        exp_rd = 0;
        exp_err = 1'b0;
        exp_ereg = 5'd0;
        exp_skip = 1'b0;
        for (int r = 0; r < 16; r++) begin
            if (r == 8) continue;
            if (lk && r <= 9) begin
                exp_skip = 1'b1;
                exp_busy += 3;
                continue;
            end
            d = rom[m * 16 + r];
            exp_q.push_back({1'b0, 8'(r)});
            exp_q.push_back({1'b1, d});
            exp_busy += 2 + 3 * (1 + GAP) + 1;
            exp_rd++;
            rb = (force_en && int'(force_idx) == r) ? force_val : (d & smask[r]);
            if (!exp_err && ((rb ^ d) & mask_of(r)) != 8'h00) begin
                exp_err = 1'b1;
                exp_ereg = 5'(r);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run1(input int m, input bit lk, input int restart_at,
                        input string tag);
        int base, rd0, busy_c, dn, n;
        bit fin;
        build(m, lk);
        base = wlog.size();
        rd0 = rd_cnt;
        busy_c = 0;
        dn = 0;
        fin = 1'b0;
        @(negedge clk);
        mode = 2'(m);
        lock = lk;
        start = 1'b1;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (busy) busy_c++;
            if (done) begin
                dn++;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        n = wlog.size() - base;
        chk({tag, "_dones"}, 32'(dn), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_c), 32'(exp_busy));
        chk({tag, "_write_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk({tag, "_write"}, 32'(wlog[base + i]), 32'(exp_q[i]));
        chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_err_reg"}, 32'(err_reg), 32'(exp_ereg));
        chk({tag, "_lock_skip"}, 32'(lock_skip), 32'(exp_skip));
    endtask

    initial begin
        int base, b2, w0, r0, dn;
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        mode = 2'd0;
        lock = 1'b0;
        force_en = 1'b0;
        force_idx = 5'd0;
        force_val = 8'h00;
        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) smask[i] = 8'hFF;

        repeat (3) @(negedge clk);
        chk("rst_strobes", {28'd0, crtc_cs, crtc_a0, crtc_write, crtc_read}, 32'd0);
        chk("rst_bus", 32'(crtc_bus), 32'd0);
        chk("rst_status", {28'd0, busy, done, err, lock_skip}, 32'd0);
        chk("rst_err_reg", 32'(err_reg), 32'd0);
        chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run1(0, 1'b0, -1, "mode0");

        rom[16 + 3] = 8'hFF;
        smask[3] = 8'h0F;
        run1(1, 1'b0, -1, "r3_mask");
        chk("r3_mask_no_err", 32'(err), 32'd0);

        rom[32 + 12] = 8'h3F;
        force_idx = 5'd12;
        force_val = 8'h01;
        force_en = 1'b1;
        run1(2, 1'b0, -1, "r12_force");
        chk("r12_force_err", 32'(err), 32'd1);
        chk("r12_force_reg", 32'(err_reg), 32'd12);
        force_en = 1'b0;
        smask[3] = 8'hFF;

        base = wlog.size();
        run1(3, 1'b1, -1, "lock");
        chk("lock_pairs", 32'(wlog.size() - base), 32'd12);

        run1(1, 1'b0, 5, "restart");

        @(negedge clk);
        mode = 2'd0;
        lock = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (crtc_write && crtc_a0 && c_idx == 5'd4) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_found_dat_r4", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write", 32'(crtc_write), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_mid_no_done", 32'(dn), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run1(0, 1'b0, -1, "post_rst");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 16; i++)
                smask[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            run1(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1,
                 "random");
        end

        w0 = w2_cnt;
        r0 = r2_cnt;
        b2 = 0;
        dn = 0;
        found = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (busy2) b2++;
            if (done2) begin
                dn++;
                found = 1'b1;
            end
        end
        start2 = 1'b0;
        chk("nv_done", 32'(dn), 32'd1);
        chk("nv_busy_cycles", 32'(b2), 32'd75);
        chk("nv_writes", 32'(w2_cnt - w0), 32'd30);
        chk("nv_reads", 32'(r2_cnt - r0), 32'd0);

        chk("bus_protocol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
